// File: rtl/touch_int_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : touch_int_filter_if
// Brief    : Signal bundle between the touch interrupt filter and its host.
// Revision : 1.0 - initial release
// ============================================================================
interface touch_int_filter_if #(
    parameter int CNT_W = 16
);
    logic             raw_int_n;
    logic             enable;
    logic             clear_counts;
    logic             clean_int_n;
    logic             event_pulse;
    logic             busy;
    logic [CNT_W-1:0] event_count;
    logic [CNT_W-1:0] reject_count;

    modport master (
        output raw_int_n, enable, clear_counts,
        input  clean_int_n, event_pulse, busy, event_count, reject_count
    );

    modport slave (
        input  raw_int_n, enable, clear_counts,
        output clean_int_n, event_pulse, busy, event_count, reject_count
    );
endinterface
`default_nettype wire

// File: rtl/touch_int_filter.sv
`default_nettype none
// ============================================================================
// Module   : touch_int_filter
// Brief    : Synchronises, debounces and shapes the touch panel interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module touch_int_filter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_LOW_CYCLES  = 4,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int TIMER_W         = 16,
    parameter int CNT_W           = 16
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    touch_int_filter_if.slave bus
);

    localparam logic [TIMER_W-1:0] c_DEB_LAST  = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_MIN_LAST  = TIMER_W'(MIN_LOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_HOLD_LAST = TIMER_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEB_FALL = 3'd1,
        S_ASSERT   = 3'd2,
        S_DEB_RISE = 3'd3,
        S_HOLDOFF  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_s1;
    logic               r_sync_n;
    logic [TIMER_W-1:0] r_timer;
    logic               r_clean_n;
    logic               r_pulse;
    logic               r_busy;
    logic [CNT_W-1:0]   r_event_count;
    logic [CNT_W-1:0]   r_reject_count;
    logic               w_event_inc;
    logic               w_reject_inc;

    assign w_event_inc  = bus.enable && (r_state == S_DEB_FALL) && !r_sync_n && (r_timer == c_DEB_LAST);
    assign w_reject_inc = bus.enable && (r_state == S_DEB_FALL) && r_sync_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1     <= 1'b1;
            r_sync_n <= 1'b1;
        end else begin
            r_s1     <= bus.raw_int_n;
            r_sync_n <= r_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_clean_n <= 1'b1;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (!bus.enable) begin
                r_state   <= S_IDLE;
                r_timer   <= '0;
                r_clean_n <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_sync_n) begin
                            r_state <= S_DEB_FALL;
                            r_timer <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_DEB_FALL: begin
                        if (r_sync_n) begin
                            r_state <= S_IDLE;
                            r_timer <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_timer == c_DEB_LAST) begin
                            r_state   <= S_ASSERT;
                            r_timer   <= '0;
                            r_clean_n <= 1'b0;
                            r_pulse   <= 1'b1;
                        end else begin
                            r_timer <= r_timer + TIMER_W'(1);
                        end
                    end
                    S_ASSERT: begin
                        // Timer saturates at the minimum width so a later bounce can re-enter here "already met".
                        if (r_timer != c_MIN_LAST) begin
                            r_timer <= r_timer + TIMER_W'(1);
                        end else if (r_sync_n) begin
                            r_state <= S_DEB_RISE;
                            r_timer <= '0;
                        end
                    end
                    S_DEB_RISE: begin
                        if (!r_sync_n) begin
                            r_state <= S_ASSERT;
                            r_timer <= c_MIN_LAST;
                        end else if (r_timer == c_DEB_LAST) begin
                            r_timer   <= '0;
                            r_clean_n <= 1'b1;
                            if (HOLDOFF_CYCLES == 0) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_HOLDOFF;
                            end
                        end else begin
                            r_timer <= r_timer + TIMER_W'(1);
                        end
                    end
                    S_HOLDOFF: begin
                        if (r_timer == c_HOLD_LAST) begin
                            r_state <= S_IDLE;
                            r_timer <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_timer <= r_timer + TIMER_W'(1);
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_timer   <= '0;
                        r_clean_n <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Clear wins over a same-cycle increment; reject count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.clear_counts) begin
            r_event_count  <= '0;
            r_reject_count <= '0;
        end else begin
            if (w_event_inc) begin
                r_event_count <= r_event_count + CNT_W'(1);
            end
            if (w_reject_inc && (r_reject_count != c_CNT_MAX)) begin
                r_reject_count <= r_reject_count + CNT_W'(1);
            end
        end
    end

    assign bus.clean_int_n  = r_clean_n;
    assign bus.event_pulse  = r_pulse;
    assign bus.busy         = r_busy;
    assign bus.event_count  = r_event_count;
    assign bus.reject_count = r_reject_count;

endmodule
`default_nettype wire
